// File: rtl/axi4_stream_rr_arbiter_if.sv
// Bundle of N upstream AXI4-Stream inputs and one tagged output stream.
// The arbiter takes the master view; the environment takes the slave view.
interface axi4_stream_rr_arbiter_if #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 4,
  parameter int ID_WIDTH   = $clog2(NUM_INPUTS)
);

  logic [NUM_INPUTS*WIDTH-1:0] s_axis_tdata;
  logic [NUM_INPUTS-1:0]       s_axis_tvalid;
  logic [NUM_INPUTS-1:0]       s_axis_tready;
  logic [WIDTH-1:0]            m_axis_tdata;
  logic                        m_axis_tvalid;
  logic                        m_axis_tready;
  logic [ID_WIDTH-1:0]         m_axis_tid;

  modport master (
    input  s_axis_tdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    output m_axis_tdata,
    output m_axis_tvalid,
    input  m_axis_tready,
    output m_axis_tid
  );

  modport slave (
    output s_axis_tdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_tdata,
    input  m_axis_tvalid,
    output m_axis_tready,
    input  m_axis_tid
  );

endinterface

// File: rtl/axi4_stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered AXI4-Stream output
// between NUM_INPUTS producers, with a per-grant burst limit.
module axi4_stream_rr_arbiter #(
  parameter int WIDTH      = 8,
  parameter int NUM_INPUTS = 4,
  parameter int MAX_BURST  = 4,
  parameter int ID_WIDTH   = $clog2(NUM_INPUTS)
) (
  input  logic                   clk,
  input  logic                   resetn,
  axi4_stream_rr_arbiter_if.master bus,
  output logic [NUM_INPUTS-1:0]  grant,
  output logic                   busy
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_q;
  logic [NUM_INPUTS-1:0] grant_q;
  logic [ID_WIDTH-1:0]   gidx_q;
  logic [ID_WIDTH-1:0]   last_q;
  logic [CW-1:0]         beat_q;
  logic                  m_valid_q;
  logic [WIDTH-1:0]      m_data_q;
  logic [ID_WIDTH-1:0]   m_id_q;

  logic [ID_WIDTH-1:0]   sel_d;
  logic [ID_WIDTH-1:0]   cand;
  logic [NUM_INPUTS-1:0] sel_oh_d;
  logic                  found_d;

  logic                  out_free;
  logic                  g_vld;
  logic                  in_xfer;
  logic                  last_beat;
  logic [WIDTH-1:0]      g_data;

  assign out_free  = !m_valid_q || bus.m_axis_tready;
  assign g_vld     = bus.s_axis_tvalid[gidx_q];
  assign in_xfer   = (state_q == GRANT) && g_vld && out_free;
  assign last_beat = (beat_q == CW'(MAX_BURST - 1));
  assign g_data    = bus.s_axis_tdata[int'(gidx_q)*WIDTH +: WIDTH];

  // Ready only for the granted input, and never while reset is held.
  assign bus.s_axis_tready =
    (resetn && state_q == GRANT && out_free) ? grant_q : '0;

  assign bus.m_axis_tdata  = m_data_q;
  assign bus.m_axis_tvalid = m_valid_q;
  assign bus.m_axis_tid    = m_id_q;
  assign grant             = grant_q;
  assign busy              = (state_q == GRANT);

  // Pick the first valid input after the last granted one, wrapping.
  always_comb begin
    sel_d    = last_q;
    cand     = last_q;
    found_d  = 1'b0;
    sel_oh_d = '0;
    for (int i = 1; i <= NUM_INPUTS; i++) begin
      cand = ID_WIDTH'((int'(last_q) + i) % NUM_INPUTS);
      if (!found_d && bus.s_axis_tvalid[cand]) begin
        found_d = 1'b1;
        sel_d   = cand;
      end
    end
    sel_oh_d[sel_d] = 1'b1;
  end

  // Grant FSM plus the output register it feeds.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      gidx_q    <= '0;
      last_q    <= ID_WIDTH'(NUM_INPUTS - 1);
      beat_q    <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_id_q    <= '0;
    end else begin
      if (m_valid_q && bus.m_axis_tready && !in_xfer)
        m_valid_q <= 1'b0;
      if (in_xfer) begin
        m_data_q  <= g_data;
        m_id_q    <= gidx_q;
        m_valid_q <= 1'b1;
        beat_q    <= beat_q + 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (found_d) begin
            state_q <= GRANT;
            grant_q <= sel_oh_d;
            gidx_q  <= sel_d;
            beat_q  <= '0;
          end
        end
        GRANT: begin
          if (!g_vld || (in_xfer && last_beat)) begin
            state_q <= IDLE;
            last_q  <= gidx_q;
            grant_q <= '0;
            beat_q  <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_stream_rr_arbiter.sv
// Scoreboard bench for the round-robin stream arbiter.
// Directed phases push expected beats; a monitor pops and compares.
module tb_axi4_stream_rr_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int MB = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic resetn;
  logic [N-1:0] grant;
  logic busy;

  always #5 clk = ~clk;

  axi4_stream_rr_arbiter_if #(.WIDTH(W), .NUM_INPUTS(N), .ID_WIDTH(IW)) bus();

  axi4_stream_rr_arbiter #(
    .WIDTH(W), .NUM_INPUTS(N), .MAX_BURST(MB), .ID_WIDTH(IW)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus),
    .grant(grant),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ncyc   = 0;

  logic [7:0]   src_q [N][$];
  logic [9:0]   exp_q [$];
  int           stamp_q [$];
  logic [N-1:0] xfer_n;
  bit           bp_mode = 1'b0;
  logic [3:0]   bp_pat  = 4'b1001;

  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data;
  logic [IW-1:0] prev_id;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int id, input logic [7:0] d);
    exp_q.push_back({IW'(id), d});
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.s_axis_tvalid[i] = (src_q[i].size() != 0);
      bus.s_axis_tdata[i*W +: W] = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding after %0d cycles",
               nm, exp_q.size(), n);
    end
    repeat (3) @(negedge clk);
    chk({nm, "_idle_grant"}, grant, 0);
    chk({nm, "_idle_busy"}, busy, 0);
    tick();
  endtask

  // Record which inputs handshake in the coming edge.
  always @(negedge clk) xfer_n = bus.s_axis_tvalid & bus.s_axis_tready;

  // Source driver: retire accepted beats, present the next ones.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < N; i++)
      if (xfer_n[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
    if (bp_mode) bus.m_axis_tready = bp_pat[cyc[1:0]];
    cyc++;
    drive();
  end

  // Monitor: scoreboard compare and stream protocol checks.
  always @(negedge clk) begin
    logic [9:0] e;
    ncyc++;
    if (resetn) begin
      if (prev_stall) begin
        chk("stall_valid", bus.m_axis_tvalid, 1);
        chk("stall_data", bus.m_axis_tdata, prev_data);
        chk("stall_id", bus.m_axis_tid, prev_id);
      end
      if (bus.m_axis_tvalid && !bus.m_axis_tready)
        chk("bp_tready", bus.s_axis_tready, 0);
      chk("onehot_ready", ($countones(bus.s_axis_tready) <= 1), 1);
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got %0h expected none",
                   {bus.m_axis_tid, bus.m_axis_tdata});
        end else begin
          e = exp_q.pop_front();
          chk("sb_beat", {bus.m_axis_tid, bus.m_axis_tdata}, e);
          stamp_q.push_back(ncyc);
        end
      end
    end
    prev_stall = resetn && bus.m_axis_tvalid && !bus.m_axis_tready;
    prev_data  = bus.m_axis_tdata;
    prev_id    = bus.m_axis_tid;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int n;
    resetn = 1'b0;
    bus.m_axis_tready = 1'b1;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) src_q[i].push_back(8'hA0 + 8'(i));
    for (int b = 0; b < 8; b++)
      for (int k = 0; k < MB; k++) push_exp(b % N, 8'hA0 + 8'(b % N));
    drive();

    // Reset held with every input requesting.
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      chk("rst_tready", bus.s_axis_tready, 0);
      chk("rst_tvalid", bus.m_axis_tvalid, 0);
      chk("rst_grant", grant, 0);
    end
    tick();
    resetn = 1'b1;
    stamp_q.delete();
    @(negedge clk);
    chk("post_rst_grant", grant, 0);
    chk("post_rst_tready", bus.s_axis_tready, 0);
    @(negedge clk);
    chk("first_grant", grant, 4'b0001);
    chk("first_busy", busy, 1);

    // Round-robin bursts of four with one bubble between grants.
    wait_drain("rr");
    chk("rr_count", stamp_q.size(), 32);
    for (int k = 0; k < 32 && k < stamp_q.size(); k++)
      chk("rr_gap", stamp_q[k] - stamp_q[0], k + k / MB);

    // Short burst from input 2, then a lone re-request.
    src_q[2].push_back(8'h11);
    src_q[2].push_back(8'h22);
    push_exp(2, 8'h11);
    push_exp(2, 8'h22);
    drive();
    wait_drain("short");
    src_q[2].push_back(8'h33);
    push_exp(2, 8'h33);
    drive();
    @(negedge clk);
    chk("regrant_idle", grant, 0);
    @(negedge clk);
    chk("regrant", grant, 4'b0100);
    wait_drain("short2");

    // Backpressure on input 1 with input 2 competing after the burst.
    bp_mode = 1'b1;
    for (int k = 1; k <= 5; k++) src_q[1].push_back(8'(k));
    src_q[2].push_back(8'h55);
    for (int k = 1; k <= 4; k++) push_exp(1, 8'(k));
    push_exp(2, 8'h55);
    push_exp(1, 8'h05);
    drive();
    wait_drain("bp");
    bp_mode = 1'b0;
    bus.m_axis_tready = 1'b1;

    // Priority rotation: last grant was input 1, so 3 beats 0.
    src_q[0].push_back(8'h0A);
    src_q[3].push_back(8'h3A);
    push_exp(3, 8'h3A);
    push_exp(0, 8'h0A);
    drive();
    @(negedge clk);
    @(negedge clk);
    chk("rot_first", grant, 4'b1000);
    wait_drain("rot");

    // Reset in the middle of a stalled burst from input 0.
    for (int k = 1; k <= 4; k++) src_q[0].push_back(8'hC0 + 8'(k));
    push_exp(0, 8'hC1);
    push_exp(0, 8'hC3);
    push_exp(0, 8'hC4);
    push_exp(1, 8'h1B);
    drive();
    n = 0;
    while (src_q[0].size() > 2 && n < 50) begin
      tick();
      n++;
    end
    bus.m_axis_tready = 1'b0;
    chk("mid_accepted", src_q[0].size(), 2);
    tick();
    resetn = 1'b0;
    src_q[1].push_back(8'h1B);
    drive();
    @(negedge clk);
    chk("mid_rst_tready", bus.s_axis_tready, 0);
    @(negedge clk);
    chk("mid_rst_tvalid", bus.m_axis_tvalid, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    tick();
    resetn = 1'b1;
    bus.m_axis_tready = 1'b1;
    @(negedge clk);
    chk("mid_post_tready", bus.s_axis_tready, 0);
    chk("mid_post_grant", grant, 0);
    @(negedge clk);
    chk("mid_regrant0", grant, 4'b0001);
    wait_drain("mid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
